// File: rtl/exp_rr_scheduler.sv
// Shared X^A engine: round-robin grant among 4 requesters, serial multiply, one result at a time.
// Latency: grant on request edge e0, o_done pulses after edge e0+A+2, next grant at e0+A+3.
// Backpressure: no ready/credit; requests are sampled only in IDLE, so waiters simply hold i_req.
module exp_rr_scheduler #(
    parameter int N_REQ = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [4*N_REQ-1:0]   i_X,
    input  logic [4*N_REQ-1:0]   i_A,
    output logic [N_REQ-1:0]     o_gnt,
    output logic                 o_busy,
    output logic [N_REQ-1:0]     o_done,
    output logic [14:0]          o_P,
    output logic [1:0]           o_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  ptr_q;
    logic [1:0]  owner_q;
    logic [3:0]  x_q;
    logic [3:0]  a_q;
    logic [3:0]  cnt_q;
    logic [14:0] p_q;
    logic [18:0] prod;
    logic        req_vld;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic        found;

    // Round-robin search starting at ptr_q, wrapping over the 4 requesters.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign req_vld = |i_req;
    assign prod    = 19'(p_q) * 19'(x_q);
    assign o_busy  = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_vld) state_d = ST_CALC;
            ST_CALC: if (cnt_q == a_q) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            x_q     <= 4'd0;
            a_q     <= 4'd0;
            cnt_q   <= 4'd0;
            p_q     <= 15'd1;
            o_gnt   <= '0;
            o_done  <= '0;
            o_P     <= 15'd0;
            o_id    <= 2'd0;
        end else begin
            o_gnt  <= '0;
            o_done <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (req_vld) begin
                        x_q     <= i_X[{win, 2'b00} +: 4];
                        a_q     <= i_A[{win, 2'b00} +: 4];
                        owner_q <= win;
                        p_q     <= 15'd1;
                        cnt_q   <= 4'd0;
                        o_gnt   <= N_REQ'(1) << win;
                        ptr_q   <= win + 2'd1;
                    end
                end
                ST_CALC: begin
                    // Product keeps only the low 15 bits; overflow is silent.
                    if (cnt_q < a_q) begin
                        p_q   <= prod[14:0];
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    o_P    <= p_q;
                    o_id   <= owner_q;
                    o_done <= N_REQ'(1) << owner_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_rr_scheduler.sv
// Directed bench for exp_rr_scheduler: job-level reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_exp_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [15:0] xv = 16'd0;
    logic [15:0] av = 16'd0;
    logic [3:0]  gnt;
    logic        busy;
    logic [3:0]  done;
    logic [14:0] p_out;
    logic [1:0]  id;

    int total = 0;
    int bad = 0;

    exp_rr_scheduler #(.N_REQ(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
        .i_X     (xv),
        .i_A     (av),
        .o_gnt   (gnt),
        .o_busy  (busy),
        .o_done  (done),
        .o_P     (p_out),
        .o_id    (id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int pow15(input int x, input int a);
        int r = 1;
        for (int i = 0; i < a; i++) r = (r * x) % 32768;
        return r;
    endfunction

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Job-level model: a job owns the engine for A+2 edges after its grant edge.
    int m_gnt = 0, m_done = 0, m_busy = 0, m_p = 0, m_id = 0;
    int m_ptr = 0, m_rem = 0, m_res = 0, m_owner = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_gnt = 0; m_done = 0; m_busy = 0; m_p = 0; m_id = 0;
            m_ptr = 0; m_rem = 0; m_res = 0; m_owner = 0;
        end else if (m_busy != 0) begin
            m_gnt = 0;
            m_done = 0;
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1 << m_owner;
                m_p    = m_res;
                m_id   = m_owner;
                m_busy = 0;
            end
        end else begin
            m_gnt = 0;
            m_done = 0;
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (m_gnt == 0 && req[k]) begin
                    m_gnt   = 1 << k;
                    m_owner = k;
                    m_res   = pow15(int'(xv[4*k +: 4]), int'(av[4*k +: 4]));
                    m_rem   = int'(av[4*k +: 4]) + 2;
                    m_busy  = 1;
                    m_ptr   = (k + 1) % 4;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt",  int'(gnt),   m_gnt);
        chk("done", int'(done),  m_done);
        chk("busy", int'(busy),  m_busy);
        chk("P",    int'(p_out), m_p);
        chk("id",   int'(id),    m_id);
    end

    // Single requester job; operands are scrambled after grant to show they were latched.
    task automatic job(input string nm, input int k, input int x, input int a,
                       input int exp_lat, input int exp_p);
        int lat;
        xv[4*k +: 4] = 4'(x);
        av[4*k +: 4] = 4'(a);
        req = 4'(1 << k);
        @(negedge clk);
        chk({nm, ".gnt"}, int'(gnt), 1 << k);
        req = 4'd0;
        xv = 16'hA5C3;
        av = 16'h3C5A;
        lat = 0;
        while (done == 4'd0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done == 4'd0) chk({nm, ".timeout"}, 0, 1);
        chk({nm, ".lat"},  lat, exp_lat);
        chk({nm, ".done"}, int'(done), 1 << k);
        chk({nm, ".P"},    int'(p_out), exp_p);
        chk({nm, ".id"},   int'(id), k);
        @(negedge clk);
    endtask

    int g_idx[16];
    int d_cyc[16];
    int d_msk[16];
    int ng, nd;

    task automatic observe(input int ncyc);
        ng = 0;
        nd = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (gnt != 4'd0 && ng < 16) begin g_idx[ng] = oh2i(gnt); ng++; end
            if (done != 4'd0 && nd < 16) begin d_cyc[nd] = c; d_msk[nd] = int'(done); nd++; end
        end
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.busy", int'(busy), 0);
        chk("rst.P",    int'(p_out), 0);
        chk("rst.id",   int'(id), 0);
        chk("rst.gnt",  int'(gnt), 0);

        job("j028", 0, 3, 4, 6, 81);
        job("j030", 2, 7, 0, 2, 1);
        job("j031", 1, 15, 4, 6, 17857);
        job("j033", 3, 2, 5, 7, 32);
        job("jx0",  0, 0, 3, 5, 0);
        job("jtrunc", 1, 7, 9, 11, 16199);

        // All four hold requests with A=1 after a fresh reset.
        pulse_reset();
        xv = 16'h5432;
        av = 16'h1111;
        req = 4'b1111;
        observe(24);
        req = 4'd0;
        if (ng < 5 || nd < 5) chk("rr.count", ng * 100 + nd, 505);
        else begin
            chk("rr.g0", g_idx[0], 0);
            chk("rr.g1", g_idx[1], 1);
            chk("rr.g2", g_idx[2], 2);
            chk("rr.g3", g_idx[3], 3);
            chk("rr.g4", g_idx[4], 0);
            for (int i = 1; i < 5; i++) chk("rr.gap", d_cyc[i] - d_cyc[i-1], 4);
            chk("rr.p3", d_msk[3], 8);
        end
        repeat (8) @(negedge clk);

        // Reset in the middle of requester 2's job, then 0 and 1 compete.
        xv[11:8] = 4'd3;
        av[11:8] = 4'd10;
        req = 4'b0100;
        @(negedge clk);
        chk("r032.gnt", int'(gnt), 4);
        req = 4'd0;
        repeat (3) @(negedge clk);
        chk("r032.busy_pre", int'(busy), 1);
        pulse_reset();
        chk("r032.P", int'(p_out), 0);
        chk("r032.busy", int'(busy), 0);
        xv[3:0] = 4'd2; av[3:0] = 4'd1;
        xv[7:4] = 4'd2; av[7:4] = 4'd2;
        req = 4'b0011;
        observe(20);
        req = 4'd0;
        if (ng < 2 || nd < 2) chk("r032.count", ng * 100 + nd, 202);
        else begin
            chk("r032.g0", g_idx[0], 0);
            chk("r032.g1", g_idx[1], 1);
            chk("r032.d0", d_msk[0], 1);
            chk("r032.d1", d_msk[1], 2);
            for (int i = 0; i < nd; i++) chk("r032.no2", d_msk[i] & 4, 0);
        end
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
